// File: rtl/shot_pkg.sv
// Shared definitions for the projectile tracer.
// Contents:
//   state_e  - tracer FSM encoding (IDLE / FLY / DONE).
//   result_e - flight termination codes (NONE / HIT / TOP / WALL).
//              The collision/score logic reuses these codes.
package shot_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FLY  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    RES_NONE = 2'd0,
    RES_HIT  = 2'd1,
    RES_TOP  = 2'd2,
    RES_WALL = 2'd3
  } result_e;

endpackage

// File: rtl/shot_step.sv
// Combinational single-step projectile kinematics.
// Computes the candidate next position from the current position and the
// latched aim vector, using 7-bit signed arithmetic so that under- and
// overflow of the 5-bit playfield can be detected.
// Configuration macro: SHOT_BOUNCE_EN (reflect at the side walls).
// Ports:
//   x_i, y_i     - current projectile column / row
//   run_i        - x step magnitude
//   rise_i       - y step
//   dir_i        - 1: x increases, 0: x decreases
//   nx_o         - next column (post-bounce when SHOT_BOUNCE_EN is defined)
//   ny_o         - next row
//   wall_o       - raw next column lies outside 0..X_MAX
//   top_o        - next row exceeds Y_MAX
//   dir_o        - next direction (inverted on a bounce)
module shot_step
  import shot_pkg::*;
#(
  parameter int X_MAX = 31,
  parameter int Y_MAX = 31
) (
  input  logic [4:0] x_i,
  input  logic [4:0] y_i,
  input  logic [4:0] run_i,
  input  logic [4:0] rise_i,
  input  logic       dir_i,
  output logic [4:0] nx_o,
  output logic [4:0] ny_o,
  output logic       wall_o,
  output logic       top_o,
  output logic       dir_o
);

  localparam logic signed [6:0] XMAX_S = 7'(X_MAX);
  localparam logic signed [6:0] YMAX_S = 7'(Y_MAX);

  logic signed [6:0] xs, ys, rs, es;
  logic signed [6:0] nx7, ny7;
`ifdef SHOT_BOUNCE_EN
  logic signed [6:0] refl;
`endif

  always_comb begin
    xs     = {2'b00, x_i};
    ys     = {2'b00, y_i};
    rs     = {2'b00, run_i};
    es     = {2'b00, rise_i};
    nx7    = dir_i ? (xs + rs) : (xs - rs);
    ny7    = ys + es;
    wall_o = (nx7 < 7'sd0) || (nx7 > XMAX_S);
    top_o  = (ny7 > YMAX_S);
    ny_o   = ny7[4:0];
`ifdef SHOT_BOUNCE_EN
    // Mirror about the violated wall, then clamp in case a large run
    // overshoots the opposite side as well.
    if (nx7 < 7'sd0) begin
      refl = -nx7;
    end else if (nx7 > XMAX_S) begin
      refl = XMAX_S + XMAX_S - nx7;
    end else begin
      refl = nx7;
    end
    if (refl < 7'sd0) begin
      refl = 7'sd0;
    end else if (refl > XMAX_S) begin
      refl = XMAX_S;
    end
    nx_o  = refl[4:0];
    dir_o = wall_o ? ~dir_i : dir_i;
`else
    nx_o  = nx7[4:0];
    dir_o = dir_i;
`endif
  end

endmodule

// File: rtl/shot_tracer.sv
// Projectile tracer: latches an aim vector on fire and advances a projectile
// across the playfield one step per game tick, reporting live coordinates
// and a registered termination result.
// Configuration macro: SHOT_BOUNCE_EN (side walls reflect instead of ending
// the flight; WALL is then never reported).
// Ports:
//   clk, reset_n         - clock, asynchronous active-low reset
//   fire                 - launch request (IDLE only)
//   tick                 - game-step strobe (FLY only)
//   hit                  - collision flag (FLY only, beats tick)
//   x_pos, run, rise, dir - aim vector, latched at launch
//   shot_x, shot_y       - projectile position
//   active / ready / done - FLY / IDLE / DONE state decode
//   result               - termination cause, held until next launch
module shot_tracer
  import shot_pkg::*;
#(
  parameter int X_MAX = 31,
  parameter int Y_MAX = 31
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       fire,
  input  logic       tick,
  input  logic       hit,
  input  logic [4:0] x_pos,
  input  logic [4:0] run,
  input  logic [4:0] rise,
  input  logic       dir,
  output logic [4:0] shot_x,
  output logic [4:0] shot_y,
  output logic       active,
  output logic       ready,
  output logic       done,
  output logic [1:0] result
);

  state_e     state_q, state_d;
  logic [4:0] x_q, x_d;
  logic [4:0] y_q, y_d;
  logic [4:0] run_q, run_d;
  logic [4:0] rise_q, rise_d;
  logic       dir_q, dir_d;
  result_e    res_q, res_d;

  logic [4:0] step_nx, step_ny;
  logic       step_wall, step_top, step_dir;

  shot_step #(
    .X_MAX(X_MAX),
    .Y_MAX(Y_MAX)
  ) u_step (
    .x_i   (x_q),
    .y_i   (y_q),
    .run_i (run_q),
    .rise_i(rise_q),
    .dir_i (dir_q),
    .nx_o  (step_nx),
    .ny_o  (step_ny),
    .wall_o(step_wall),
    .top_o (step_top),
    .dir_o (step_dir)
  );

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    run_d   = run_q;
    rise_d  = rise_q;
    dir_d   = dir_q;
    res_d   = res_q;
    unique case (state_q)
      ST_IDLE: begin
        if (fire) begin
          run_d   = run;
          // Zero rise would never reach the top row; force progress.
          rise_d  = (rise == 5'd0) ? 5'd1 : rise;
          dir_d   = dir;
          x_d     = x_pos;
          y_d     = '0;
          res_d   = RES_NONE;
          state_d = ST_FLY;
        end
      end
      ST_FLY: begin
        if (hit) begin
          res_d   = RES_HIT;
          state_d = ST_DONE;
        end else if (tick) begin
          if (step_top) begin
            res_d   = RES_TOP;
            state_d = ST_DONE;
`ifndef SHOT_BOUNCE_EN
          end else if (step_wall) begin
            res_d   = RES_WALL;
            state_d = ST_DONE;
`endif
          end else begin
            x_d   = step_nx;
            y_d   = step_ny;
            dir_d = step_dir;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      run_q   <= '0;
      rise_q  <= '0;
      dir_q   <= 1'b0;
      res_q   <= RES_NONE;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      run_q   <= run_d;
      rise_q  <= rise_d;
      dir_q   <= dir_d;
      res_q   <= res_d;
    end
  end

  assign shot_x = x_q;
  assign shot_y = y_q;
  assign result = res_q;
  assign active = (state_q == ST_FLY);
  assign ready  = (state_q == ST_IDLE);
  assign done   = (state_q == ST_DONE);

endmodule

// File: tb/tb_shot_tracer.sv
// Directed bench for shot_tracer with an expectation queue.
module tb_shot_tracer;
  import shot_pkg::*;

  logic       clk;
  logic       reset_n;
  logic       fire, tick, hit;
  logic [4:0] x_pos, run, rise;
  logic       dir;
  logic [4:0] shot_x, shot_y;
  logic       active, ready, done;
  logic [1:0] result;

  typedef struct packed {
    logic [4:0] x;
    logic [4:0] y;
    logic [1:0] res;
    logic       act;
    logic       rdy;
    logic       dn;
  } obs_t;

  obs_t  exp_q[$];
  string tag_q[$];
  int    checks   = 0;
  int    failures = 0;

  shot_tracer #(
    .X_MAX(31),
    .Y_MAX(31)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .fire   (fire),
    .tick   (tick),
    .hit    (hit),
    .x_pos  (x_pos),
    .run    (run),
    .rise   (rise),
    .dir    (dir),
    .shot_x (shot_x),
    .shot_y (shot_y),
    .active (active),
    .ready  (ready),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected observation builders for each state.
  function automatic obs_t e_fly(input int x, input int y);
    return '{x: 5'(x), y: 5'(y), res: RES_NONE, act: 1'b1, rdy: 1'b0, dn: 1'b0};
  endfunction
  function automatic obs_t e_done(input int x, input int y, input result_e r);
    return '{x: 5'(x), y: 5'(y), res: r, act: 1'b0, rdy: 1'b0, dn: 1'b1};
  endfunction
  function automatic obs_t e_idle(input int x, input int y, input result_e r);
    return '{x: 5'(x), y: 5'(y), res: r, act: 1'b0, rdy: 1'b1, dn: 1'b0};
  endfunction

  task automatic compare_front();
    obs_t  e;
    obs_t  o;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    o = '{x: shot_x, y: shot_y, res: result, act: active, rdy: ready, dn: done};
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed x=%0d y=%0d res=%0d act=%b rdy=%b done=%b expected x=%0d y=%0d res=%0d act=%b rdy=%b done=%b",
             t, o.x, o.y, o.res, o.act, o.rdy, o.dn, e.x, e.y, e.res, e.act, e.rdy, e.dn);
    end
  endtask

  // Check current outputs without clocking.
  task automatic expect_now(input obs_t e, input string tag);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    compare_front();
  endtask

  // Drive one cycle of control inputs, then check the post-edge outputs.
  task automatic step(input logic f, input logic t, input logic h,
                      input obs_t e, input string tag);
    fire = f;
    tick = t;
    hit  = h;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    fire = 1'b0;
    tick = 1'b0;
    hit  = 1'b0;
    compare_front();
  endtask

  task automatic aim(input int x, input int r, input int e, input logic d);
    x_pos = 5'(x);
    run   = 5'(r);
    rise  = 5'(e);
    dir   = d;
  endtask

  initial begin
    reset_n = 1'b0;
    fire = 1'b0; tick = 1'b0; hit = 1'b0;
    aim(0, 0, 0, 1'b0);
    @(posedge clk);
    #1;
    expect_now(e_idle(0, 0, RES_NONE), "reset");
    reset_n = 1'b1;
    step(1'b0, 1'b1, 1'b0, e_idle(0, 0, RES_NONE), "idle_tick_ignored");

    // 1: diagonal climb to the top row
    aim(10, 1, 2, 1'b1);
    step(1'b1, 1'b0, 1'b0, e_fly(10, 0), "t1_launch");
    for (int i = 1; i <= 15; i++) begin
      step(1'b0, 1'b1, 1'b0, e_fly(10 + i, 2 * i), $sformatf("t1_tick%0d", i));
    end
    step(1'b0, 1'b1, 1'b0, e_done(25, 30, RES_TOP), "t1_top");
    step(1'b1, 1'b0, 1'b0, e_idle(25, 30, RES_TOP), "t1_fire_in_done_ignored");

    // 2: vertical shot, coincident tick at launch does not move it
    aim(5, 0, 1, 1'b1);
    step(1'b1, 1'b1, 1'b0, e_fly(5, 0), "t2_launch_tick");
    for (int i = 1; i <= 31; i++) begin
      step(1'b0, 1'b1, 1'b0, e_fly(5, i), $sformatf("t2_tick%0d", i));
    end
    step(1'b0, 1'b1, 1'b0, e_done(5, 31, RES_TOP), "t2_top");
    step(1'b0, 1'b0, 1'b0, e_idle(5, 31, RES_TOP), "t2_idle");

    // 3: left wall
    aim(1, 2, 1, 1'b0);
    step(1'b1, 1'b0, 1'b0, e_fly(1, 0), "t3_launch");
`ifdef SHOT_BOUNCE_EN
    step(1'b0, 1'b1, 1'b0, e_fly(1, 1), "t3_bounce");
    step(1'b0, 1'b1, 1'b0, e_fly(3, 2), "t3_after_bounce");
    step(1'b0, 1'b0, 1'b1, e_done(3, 2, RES_HIT), "t3_hit");
    step(1'b0, 1'b0, 1'b0, e_idle(3, 2, RES_HIT), "t3_idle");
`else
    step(1'b0, 1'b1, 1'b0, e_done(1, 0, RES_WALL), "t3_wall");
    step(1'b0, 1'b0, 1'b0, e_idle(1, 0, RES_WALL), "t3_idle");
`endif

    // 4: hit beats tick
    aim(7, 3, 4, 1'b1);
    step(1'b1, 1'b0, 1'b0, e_fly(7, 0), "t4_launch");
    step(1'b0, 1'b1, 1'b0, e_fly(10, 4), "t4_tick");
    step(1'b0, 1'b1, 1'b1, e_done(10, 4, RES_HIT), "t4_hit_tick");
    step(1'b0, 1'b0, 1'b0, e_idle(10, 4, RES_HIT), "t4_done_one_cycle");

    // 5: zero rise forced to 1; fire and aim changes during flight ignored
    aim(20, 1, 0, 1'b0);
    step(1'b1, 1'b0, 1'b0, e_fly(20, 0), "t5_launch");
    aim(3, 5, 7, 1'b1);
    step(1'b1, 1'b1, 1'b0, e_fly(19, 1), "t5_fire_tick_in_fly");
    step(1'b1, 1'b0, 1'b0, e_fly(19, 1), "t5_fire_in_fly");
    step(1'b0, 1'b1, 1'b0, e_fly(18, 2), "t5_tick2");
    step(1'b0, 1'b0, 1'b1, e_done(18, 2, RES_HIT), "t5_hit");
    step(1'b0, 1'b0, 1'b0, e_idle(18, 2, RES_HIT), "t5_idle");

    // 6: asynchronous reset mid-flight
    aim(4, 2, 3, 1'b1);
    step(1'b1, 1'b0, 1'b0, e_fly(4, 0), "t6_launch");
    step(1'b0, 1'b1, 1'b0, e_fly(6, 3), "t6_tick1");
    step(1'b0, 1'b1, 1'b0, e_fly(8, 6), "t6_tick2");
    step(1'b0, 1'b1, 1'b0, e_fly(10, 9), "t6_tick3");
    #2;
    reset_n = 1'b0;
    #1;
    expect_now(e_idle(0, 0, RES_NONE), "t6_async_reset");
    tick = 1'b1;
    @(posedge clk);
    #1;
    tick = 1'b0;
    expect_now(e_idle(0, 0, RES_NONE), "t6_reset_held_no_done");
    reset_n = 1'b1;
    step(1'b1, 1'b0, 1'b0, e_fly(4, 0), "t6_relaunch");
    step(1'b0, 1'b1, 1'b0, e_fly(6, 3), "t6_relaunch_tick");
    step(1'b0, 1'b0, 1'b1, e_done(6, 3, RES_HIT), "t6_hit");
    step(1'b0, 1'b0, 1'b0, e_idle(6, 3, RES_HIT), "t6_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
